issue_scheduler: RTL and testbench

Issue-select controller for the out-of-order core's reservation station. It tracks RS entry occupancy and relative age, picks the oldest operand-ready entry whose functional unit and CDB write-back slot are free, and grants at most one issue per cycle. It sits between the RS entry array, which supplies per-entry ready bits and receives the grant, and the ALU/MUL/DIV functional units, which share one CDB.

---
 rtl/issue_scheduler.sv | 117 +++++++++++
 tb/tb_issue_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Oldest-first issue select over the RS entries, gated by FU availability and CDB write-back slot.
// Grant is combinational in the current cycle; state updates on the clock edge.
module issue_scheduler #(
  parameter int RS_DEPTH = 8,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_valid,
  input  logic [$clog2(RS_DEPTH)-1:0] alloc_idx,
  input  logic [1:0]                  alloc_fu,
  input  logic [RS_DEPTH-1:0]         entry_ready,
  input  logic                        flush,
  output logic                        issue_valid,
  output logic [$clog2(RS_DEPTH)-1:0] issue_idx,
  output logic [1:0]                  issue_fu,
  output logic                        rs_full,
  output logic                        div_busy
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int RW = $clog2(DIV_LAT);
  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_DIV = 2'd2;

  logic [RS_DEPTH-1:0]               valid;
  logic [1:0]                        fu [RS_DEPTH];
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older;
  logic [CW-1:0]                     div_cnt;
  logic [DIV_LAT-1:0]                res;

  logic [RS_DEPTH-1:0] elig, win, gnt_oh, valid_after, valid_next;
  logic                found, grant, alloc_ok;
  logic [IW-1:0]       pick;
  logic [DIV_LAT-1:0]  res_next;
  logic [CW-1:0]       div_next;
  logic [1:0]          alloc_fu_n;

  // Reservation bit that must be clear for a class: bit k is the CDB slot k+1 cycles ahead.
  function automatic logic [RW-1:0] res_slot(input logic [1:0] f);
    case (f)
      FU_MUL:  return RW'(MUL_LAT - 1);
      FU_DIV:  return RW'(DIV_LAT - 1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    elig  = '0;
    win   = '0;
    found = 1'b0;
    pick  = '0;
    // The divider hands off in its final busy cycle, so back-to-back DIVs are DIV_LAT apart.
    for (int i = 0; i < RS_DEPTH; i++)
      elig[i] = valid[i] && entry_ready[i] && !res[res_slot(fu[i])] &&
                (fu[i] != FU_DIV || div_cnt <= CW'(1));
    for (int i = 0; i < RS_DEPTH; i++) begin
      win[i] = elig[i];
      for (int j = 0; j < RS_DEPTH; j++)
        if (j != i && elig[j] && older[j][i]) win[i] = 1'b0;
    end
    for (int i = 0; i < RS_DEPTH; i++)
      if (win[i] && !found) begin
        found = 1'b1;
        pick  = IW'(i);
      end
  end

  assign grant       = found && !flush;
  assign issue_valid = grant;
  assign issue_idx   = grant ? pick : '0;
  assign issue_fu    = grant ? fu[pick] : FU_ALU;
  assign rs_full     = &valid;
  assign div_busy    = (div_cnt != '0);

  always_comb begin
    gnt_oh = '0;
    if (grant) gnt_oh[pick] = 1'b1;
    valid_after = valid & ~gnt_oh;
    // Allocating over a live, ungranted entry is dropped rather than corrupting it.
    alloc_ok   = alloc_valid && !flush && !valid_after[alloc_idx];
    alloc_fu_n = (alloc_fu == 2'd3) ? FU_ALU : alloc_fu;
    valid_next = flush ? '0 : valid_after;
    if (alloc_ok) valid_next[alloc_idx] = 1'b1;

    res_next = res;
    if (grant) res_next[res_slot(fu[pick])] = 1'b1;
    res_next = res_next >> 1;

    div_next = div_cnt;
    if (div_cnt != '0) div_next = div_cnt - CW'(1);
    if (grant && fu[pick] == FU_DIV) div_next = CW'(DIV_LAT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= '0;
      older   <= '0;
      res     <= '0;
      div_cnt <= '0;
      for (int i = 0; i < RS_DEPTH; i++) fu[i] <= FU_ALU;
    end else begin
      valid   <= valid_next;
      res     <= res_next;
      div_cnt <= div_next;
      if (alloc_ok) begin
        fu[alloc_idx] <= alloc_fu_n;
        for (int j = 0; j < RS_DEPTH; j++) begin
          older[alloc_idx][j] <= 1'b0;
          older[j][alloc_idx] <= valid_after[j];
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: age order, CDB slots, divider occupancy, reuse, flush, reset.
module tb_issue_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic [2:0] alloc_idx;
  logic [1:0] alloc_fu;
  logic [7:0] entry_ready;
  logic       flush;
  logic       issue_valid;
  logic [2:0] issue_idx;
  logic [1:0] issue_fu;
  logic       rs_full;
  logic       div_busy;

  int total = 0;
  int bad   = 0;
  logic [5:0] got, exp;
  assign got = {issue_valid, issue_idx, issue_fu};

  int ord_idx [8] = '{0, 1, 3, 4, 5, 6, 7, 2};
  int ord_fu  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  issue_scheduler #(.RS_DEPTH(8), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_fu(alloc_fu), .entry_ready(entry_ready), .flush(flush),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_fu(issue_fu),
    .rs_full(rs_full), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    @(negedge clk);
    reset = 1'b1; alloc_valid = 1'b0; alloc_idx = '0; alloc_fu = '0;
    entry_ready = '0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task do_alloc(input int idx, input logic [1:0] f);
    alloc_valid = 1'b1; alloc_idx = 3'(idx); alloc_fu = f;
    tick();
    alloc_valid = 1'b0;
  endtask

  task test_reset();
    reset = 1'b1; alloc_valid = 1'b0; alloc_idx = '0; alloc_fu = '0;
    entry_ready = 8'hFF; flush = 1'b0;
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL reset_issue got=%h exp=%h", got, exp); end
    total++;
    if ({rs_full, div_busy} !== 2'b00) begin bad++; $display("FAIL reset_full_busy got=%b exp=00", {rs_full, div_busy}); end
    @(negedge clk);
    reset = 1'b0;
    entry_ready = '0;
  endtask

  task test_age_order();
    do_reset();
    do_alloc(3, 2'd0);
    do_alloc(1, 2'd0);
    do_alloc(5, 2'd0);
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL age_not_ready got=%h exp=%h", got, exp); end
    tick();
    entry_ready = 8'h2A;
    @(negedge clk);
    exp = {1'b1, 3'd3, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL age_first got=%h exp=%h", got, exp); end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd1, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL age_second got=%h exp=%h", got, exp); end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd5, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL age_third got=%h exp=%h", got, exp); end
    tick();
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL age_drained got=%h exp=%h", got, exp); end
  endtask

  task test_cdb_conflict();
    do_reset();
    do_alloc(0, 2'd1);
    do_alloc(1, 2'd2);
    do_alloc(2, 2'd0);
    entry_ready = 8'h07;
    @(negedge clk);
    exp = {1'b1, 3'd0, 2'd1}; total++;
    if (got !== exp) begin bad++; $display("FAIL cdb_mul got=%h exp=%h", got, exp); end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd1, 2'd2}; total++;
    if (got !== exp) begin bad++; $display("FAIL cdb_div got=%h exp=%h", got, exp); end
    tick();
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL cdb_alu_blocked got=%h exp=%h", got, exp); end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd2, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL cdb_alu_late got=%h exp=%h", got, exp); end
  endtask

  task test_div_occupancy();
    do_reset();
    do_alloc(0, 2'd2);
    do_alloc(1, 2'd2);
    do_alloc(2, 2'd0);
    entry_ready = 8'h03;
    @(negedge clk);
    exp = {1'b1, 3'd0, 2'd2}; total++;
    if (got !== exp) begin bad++; $display("FAIL div_first got=%h exp=%h", got, exp); end
    total++;
    if (div_busy !== 1'b0) begin bad++; $display("FAIL div_idle_c0 got=%b exp=0", div_busy); end
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 7) entry_ready = 8'h07;
      @(negedge clk);
      exp = 6'd0; total++;
      if (got !== exp) begin bad++; $display("FAIL div_wait_c%0d got=%h exp=%h", c, got, exp); end
      total++;
      if (div_busy !== 1'b1) begin bad++; $display("FAIL div_busy_c%0d got=%b exp=1", c, div_busy); end
    end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd1, 2'd2}; total++;
    if (got !== exp) begin bad++; $display("FAIL div_second got=%h exp=%h", got, exp); end
    total++;
    if (div_busy !== 1'b1) begin bad++; $display("FAIL div_busy_c8 got=%b exp=1", div_busy); end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd2, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL div_alu_after got=%h exp=%h", got, exp); end
    total++;
    if (div_busy !== 1'b1) begin bad++; $display("FAIL div_busy_c9 got=%b exp=1", div_busy); end
  endtask

  task test_full_reuse();
    do_reset();
    for (int k = 0; k < 8; k++) do_alloc(k, 2'd0);
    alloc_valid = 1'b1; alloc_idx = 3'd5; alloc_fu = 2'd2;
    @(negedge clk);
    total++;
    if (rs_full !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp=1", rs_full); end
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL full_idle got=%h exp=%h", got, exp); end
    tick();
    alloc_valid = 1'b1; alloc_idx = 3'd2; alloc_fu = 2'd1; entry_ready = 8'h04;
    @(negedge clk);
    exp = {1'b1, 3'd2, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL reuse_grant got=%h exp=%h", got, exp); end
    tick();
    alloc_valid = 1'b0; entry_ready = 8'hFF;
    @(negedge clk);
    total++;
    if (rs_full !== 1'b1) begin bad++; $display("FAIL reuse_full got=%b exp=1", rs_full); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      exp = {1'b1, 3'(ord_idx[k]), 2'(ord_fu[k])}; total++;
      if (got !== exp) begin bad++; $display("FAIL reuse_order_%0d got=%h exp=%h", k, got, exp); end
    end
    total++;
    if (rs_full !== 1'b0) begin bad++; $display("FAIL reuse_not_full got=%b exp=0", rs_full); end
  endtask

  task test_flush();
    do_reset();
    do_alloc(7, 2'd2);
    entry_ready = 8'h80;
    alloc_valid = 1'b1; alloc_idx = 3'd0; alloc_fu = 2'd0;
    @(negedge clk);
    exp = {1'b1, 3'd7, 2'd2}; total++;
    if (got !== exp) begin bad++; $display("FAIL flush_div got=%h exp=%h", got, exp); end
    tick();
    for (int k = 1; k <= 4; k++) do_alloc(k, 2'd0);
    flush = 1'b1; alloc_valid = 1'b1; alloc_idx = 3'd5; alloc_fu = 2'd0; entry_ready = 8'hFF;
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL flush_suppress got=%h exp=%h", got, exp); end
    total++;
    if (div_busy !== 1'b1) begin bad++; $display("FAIL flush_busy_c0 got=%b exp=1", div_busy); end
    tick();
    flush = 1'b0; alloc_valid = 1'b1; alloc_idx = 3'd6; alloc_fu = 2'd0;
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL flush_cleared got=%h exp=%h", got, exp); end
    total++;
    if ({rs_full, div_busy} !== 2'b01) begin bad++; $display("FAIL flush_c1 got=%b exp=01", {rs_full, div_busy}); end
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL flush_res_kept got=%h exp=%h", got, exp); end
    total++;
    if (div_busy !== 1'b1) begin bad++; $display("FAIL flush_busy_c2 got=%b exp=1", div_busy); end
    tick();
    @(negedge clk);
    exp = {1'b1, 3'd6, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL flush_alu got=%h exp=%h", got, exp); end
    total++;
    if (div_busy !== 1'b1) begin bad++; $display("FAIL flush_busy_c3 got=%b exp=1", div_busy); end
    tick();
    @(negedge clk);
    total++;
    if (div_busy !== 1'b0) begin bad++; $display("FAIL flush_busy_c4 got=%b exp=0", div_busy); end
  endtask

  task test_reset_mid();
    do_reset();
    do_alloc(0, 2'd2);
    entry_ready = 8'h01;
    alloc_valid = 1'b1; alloc_idx = 3'd1; alloc_fu = 2'd0;
    @(negedge clk);
    exp = {1'b1, 3'd0, 2'd2}; total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_div got=%h exp=%h", got, exp); end
    tick();
    alloc_valid = 1'b0; entry_ready = 8'h03;
    #1;
    exp = {1'b1, 3'd1, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_pre got=%h exp=%h", got, exp); end
    reset = 1'b1;
    #1;
    exp = 6'd0; total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_async_issue got=%h exp=%h", got, exp); end
    total++;
    if ({rs_full, div_busy} !== 2'b00) begin bad++; $display("FAIL rmid_async_busy got=%b exp=00", {rs_full, div_busy}); end
    @(negedge clk);
    reset = 1'b0; entry_ready = 8'h00;
    tick();
    tick();
    tick();
    do_alloc(4, 2'd2);
    alloc_valid = 1'b1; alloc_idx = 3'd3; alloc_fu = 2'd0; entry_ready = 8'h18;
    @(negedge clk);
    exp = {1'b1, 3'd4, 2'd2}; total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_div_free got=%h exp=%h", got, exp); end
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    exp = {1'b1, 3'd3, 2'd0}; total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_alu got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_cdb_conflict();
    test_div_occupancy();
    test_full_reuse();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
